// File: rtl/cpu_run_controller.sv
// Host-side sequencer for the pipelined CPU: clears data memory, streams in a program,
// runs the core for a programmed cycle budget, then serves data-memory readback.
module cpu_run_controller #(
   parameter int IMEM_WORDS = 512,
   parameter int DMEM_WORDS = 1024,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] run_cycles,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [31:0]      ld_data,
   input  logic             ld_last,
   input  logic             rd_req,
   input  logic [9:0]       rd_addr,
   output logic             rd_valid,
   output logic [31:0]      rd_data,
   output logic             cpu_enable,
   output logic             cpu_rst_n,
   output logic [31:0]      imem_addr,
   output logic             imem_wen,
   output logic [31:0]      imem_wdata,
   output logic [31:0]      dmem_addr,
   output logic             dmem_wen,
   output logic             dmem_ren,
   output logic [31:0]      dmem_wdata,
   input  logic [31:0]      dmem_rdata,
   output logic             busy,
   output logic             done,
   output logic             trunc,
   output logic [CNT_W-1:0] cycles_run
);

   localparam int IDX_IW = $clog2(IMEM_WORDS);
   localparam int IDX_DW = $clog2(DMEM_WORDS);
   localparam logic [IDX_IW-1:0] LOAD_LAST  = IDX_IW'(IMEM_WORDS - 1);
   localparam logic [IDX_DW-1:0] CLEAR_LAST = IDX_DW'(DMEM_WORDS - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DONE} state_t;

   state_t            state, state_next;
   logic [IDX_DW-1:0] clear_idx;
   logic [IDX_IW-1:0] load_idx;
   logic [CNT_W-1:0]  budget;
   logic [CNT_W-1:0]  cnt_next;
   logic              start_ok;
   logic              ld_fire;
   logic              load_exit;

   assign start_ok   = start && (state == IDLE || state == DONE);
   assign ld_fire    = ld_valid && (state == LOAD);
   assign load_exit  = ld_fire && (ld_last || load_idx == LOAD_LAST);
   assign cnt_next   = (cycles_run == {CNT_W{1'b1}}) ? cycles_run : cycles_run + 1'b1;
   assign dmem_wdata = '0;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start_ok) state_next = CLEAR;
         CLEAR:   if (clear_idx == CLEAR_LAST) state_next = LOAD;
         LOAD:    if (load_exit) state_next = (budget == '0) ? DONE : RUN;
         RUN:     if (cpu_enable && cnt_next == budget) state_next = DONE;
         DONE:    if (start_ok) state_next = CLEAR;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == CLEAR) || (state == LOAD) || (state == RUN);
      done     = (state == DONE);
      ld_ready = (state == LOAD);
      rd_data  = rd_valid ? dmem_rdata : '0;
   end

   // Memory ports and CPU controls are registered, so each lags its deciding state by one cycle.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         clear_idx  <= '0;
         load_idx   <= '0;
         budget     <= '0;
         cycles_run <= '0;
         trunc      <= 1'b0;
         cpu_enable <= 1'b0;
         cpu_rst_n  <= 1'b0;
         imem_addr  <= '0;
         imem_wen   <= 1'b0;
         imem_wdata <= '0;
         dmem_addr  <= '0;
         dmem_wen   <= 1'b0;
         dmem_ren   <= 1'b0;
         rd_valid   <= 1'b0;
      end else begin
         dmem_wen <= 1'b0;
         dmem_ren <= 1'b0;
         imem_wen <= 1'b0;
         rd_valid <= dmem_ren;
         if (start_ok) begin
            budget     <= run_cycles;
            trunc      <= 1'b0;
            cycles_run <= '0;
            clear_idx  <= '0;
            load_idx   <= '0;
            cpu_rst_n  <= 1'b0;
            cpu_enable <= 1'b0;
         end
         case (state)
            CLEAR: begin
               dmem_wen  <= 1'b1;
               dmem_addr <= 32'({clear_idx, 2'b00});
               clear_idx <= clear_idx + 1'b1;
            end
            LOAD: begin
               if (ld_fire) begin
                  imem_wen   <= 1'b1;
                  imem_addr  <= 32'({load_idx, 2'b00});
                  imem_wdata <= ld_data;
                  load_idx   <= load_idx + 1'b1;
                  if (load_exit) begin
                     trunc     <= (load_idx == LOAD_LAST) && !ld_last;
                     cpu_rst_n <= 1'b1;
                  end
               end
            end
            RUN: begin
               // First RUN cycle only releases CPU reset; enable follows one cycle later.
               if (!cpu_enable) begin
                  cpu_enable <= 1'b1;
               end else begin
                  cycles_run <= cnt_next;
                  if (cnt_next == budget) cpu_enable <= 1'b0;
               end
            end
            DONE: begin
               if (rd_req && !start) begin
                  dmem_ren  <= 1'b1;
                  dmem_addr <= 32'({rd_addr, 2'b00});
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Host-side sequencer for the pipelined CPU. It zeroes data memory, streams a program into instruction memory, runs the core for a programmed cycle budget, then serves data-memory readback.
- Sits between the host and the CPU: it drives the CPU's enable, reset and both external memory ports (addr_ext/wen_ext/ren_ext/wdata_ext and the _2 set).

Parameters:
- IMEM_WORDS, 512, instruction memory depth in words.
- DMEM_WORDS, 1024, data memory depth in words.
- CNT_W, 16, width of the cycle budget and cycle counter.

Ports:
- clk  input  1  main clock
- arst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; accepted only in IDLE or DONE
- run_cycles  input  CNT_W  cycle budget, sampled when start is accepted
- ld_valid  input  1  program word valid
- ld_ready  output  1  program word accepted when ld_valid & ld_ready
- ld_data  input  32  program word
- ld_last  input  1  marks final program word
- rd_req  input  1  readback request; honoured only in DONE
- rd_addr  input  10  readback data-memory word index
- rd_valid  output  1  readback data valid
- rd_data  output  32  readback data
- cpu_enable  output  1  to CPU enable
- cpu_rst_n  output  1  to CPU arst_n (registered)
- imem_addr  output  32  to CPU addr_ext (byte address = word index<<2)
- imem_wen  output  1  to wen_ext
- imem_wdata  output  32  to wdata_ext
- dmem_addr  output  32  to addr_ext_2 (byte address)
- dmem_wen  output  1  to wen_ext_2
- dmem_ren  output  1  to ren_ext_2
- dmem_wdata  output  32  to wdata_ext_2
- dmem_rdata  input  32  from rdata_ext_2
- busy  output  1  high in CLEAR/LOAD/RUN
- done  output  1  high in DONE
- trunc  output  1  program truncated at IMEM_WORDS
- cycles_run  output  CNT_W  cycles executed in last RUN

Behaviour:
- Reset values: state IDLE; all outputs 0 except cpu_rst_n=0. Counters clear. Reset mid-operation aborts immediately to IDLE; memory contents are undefined.
- Memory-port timing:
  - All memory-port outputs are registered.
  - imem_ren is tied 0.
  - dmem_rdata is valid one cycle after dmem_ren.
- State IDLE: cpu_rst_n=0, cpu_enable=0. On start, latch run_cycles, clear trunc and cycles_run, go to CLEAR.
- State CLEAR:
  - One write per cycle: dmem_wen=1, dmem_wdata=0, dmem_addr=i<<2 for i=0..DMEM_WORDS-1 (exactly DMEM_WORDS cycles).
  - After the final write, go to LOAD with load index j=0.
- State LOAD:
  - ld_ready=1.
  - On each handshake, the next cycle drives imem_wen=1, imem_addr=j<<2, imem_wdata=ld_data, then j++.
  - ld_valid low inserts bubbles with no write.
  - Exit after the word carrying ld_last, or after the word at j=IMEM_WORDS-1 regardless of ld_last.
  - In the IMEM_WORDS-1 case, trunc=1 if ld_last was 0. ld_ready drops the cycle after the exit handshake.
  - Exit to RUN; if the latched budget is 0, exit directly to DONE.
- State RUN:
  - On entry, cpu_rst_n goes 1 one cycle before cpu_enable goes 1.
  - cpu_enable is high for exactly run_cycles cycles; cycles_run increments each enabled cycle.
  - When cycles_run reaches the budget, deassert cpu_enable the next cycle and go to DONE.
- State DONE:
  - cpu_rst_n stays 1 and cpu_enable 0 (CPU frozen).
  - On rd_req: dmem_ren=1, dmem_addr=rd_addr<<2 next cycle; rd_valid=1 with rd_data=dmem_rdata one cycle after that (2-cycle latency).
  - Back-to-back rd_req is supported at one per cycle.
  - rd_req outside DONE is ignored; rd_valid stays 0.
  - start in DONE restarts at CLEAR (reasserting cpu_rst_n=0).
- Simultaneous events:
  - start and rd_req in the same DONE cycle: start wins and the read is dropped.
  - start outside IDLE/DONE is ignored.
- Memory writes never overlap: dmem writes occur only in CLEAR, imem writes only in LOAD; no writes in RUN or DONE.
- Widths: addresses are zero-extended to 32 bits; the cycle counter saturates at 2^CNT_W-1.

Test Plan:
- Reset then start with run_cycles=10 and 3 words (0x20010005, 0x20020007, 0x00221820, last on word 3) → 1024 dmem zero writes, imem writes at byte addresses 0x0/0x4/0x8, cpu_enable high exactly 10 cycles, done=1, cycles_run=10, trunc=0.
- ld_valid toggling 1,0,0,1 → exactly 2 imem writes at addresses 0x0 and 0x4, no write in the bubble cycles.
- Stream 513 words with ld_last never set → 512 writes, last at byte address 0x7FC, ld_ready low after word 512, trunc=1.
- run_cycles=0 → LOAD goes straight to DONE, cpu_enable never asserts, cycles_run=0.
- In DONE, rd_req at word indices 5, 6 on consecutive cycles with a memory model returning 0xA5, 0xA6 → rd_valid on 2 consecutive cycles with rd_data 0xA5 then 0xA6; rd_req during RUN → no dmem_ren.
- arst_n low mid-RUN at cycle 4 → all outputs return to reset values asynchronously; next start begins CLEAR at address 0.
